uart_rx_flow: RTL and testbench

//  UART receive front-end between the FTDI TXD pin and the system bus logic.

---
 rtl/uart_rx_flow_if.sv | 20 ++
 rtl/uart_rx_flow.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_rx_flow.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_flow_if.sv
// Byte stream from the UART receive FIFO to the system bus logic.
// master drives data/valid, slave returns ready; a transfer happens on
// every clock where m_valid and m_ready are both high.
interface uart_rx_flow_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_flow.sv
// UART receive front-end: 2-FF synchroniser, 8N1 deserialiser, show-ahead
// byte FIFO behind a valid/ready port, and registered RTS flow control.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1, adds a
// PARITY state and a parity_err pulse output.
module uart_rx_flow #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RTS_THRESH = 12
) (
    input  logic                             clk_100mhz,
    input  logic                             resetn,
    input  logic                             uart_rxd,
    output logic                             uart_rtsn,
    uart_rx_flow_if.master                   m,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             frame_err,
    output logic                             overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                             parity_err
`endif
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned TW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);

    // Timer counts down to zero, so loads are one less than the interval.
    localparam logic [TW-1:0] FULL_LD = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LD = TW'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Line synchroniser
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    // Receive FSM
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          push_q;
    logic          frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q;
    logic          parity_err_q;
`endif

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          overrun_q, overrun_d;
    logic          rts_q;

    logic          pop;
    logic          full;
    logic          do_push;
    logic          timer_done;

    assign timer_done = (timer_q == '0);

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Frame FSM: mid-bit sampling, shift LSB first, registered push/error pulses.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= S_START;
                        timer_q <= HALF_LD;
                    end
                end
                S_START: begin
                    if (timer_done) begin
                        timer_q <= FULL_LD;
                        if (!rx_sync_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer_done) begin
                        timer_q <= FULL_LD;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (timer_done) begin
                        timer_q   <= FULL_LD;
                        par_bad_q <= ^{shift_q, rx_sync_q};
                        state_q   <= S_STOP;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (timer_done) begin
                        timer_q <= FULL_LD;
                        if (rx_sync_q) begin
                            state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                push_q <= 1'b1;
                            end
`else
                            push_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_sync_q) begin
                        state_q <= S_IDLE;
                        timer_q <= FULL_LD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO next state; the head register is refilled from the post-update
    // read pointer, bypassing the write data when it becomes the only entry.
    always_comb begin
        pop       = m_valid_q & m.m_ready;
        full      = (count_q == LW'(FIFO_DEPTH));
        do_push   = push_q & (~full | pop);
        overrun_d = push_q & full & ~pop;

        count_d = count_q;
        if (do_push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !do_push) begin
            count_d = count_q - LW'(1);
        end

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

        m_valid_d = (count_d != '0);
        m_data_d  = m_data_q;
        if (count_d != '0) begin
            if (do_push && count_d == LW'(1)) begin
                m_data_d = shift_q;
            end else begin
                m_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO storage, pointers, registered stream outputs and RTS.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            overrun_q <= overrun_d;
            rts_q     <= (count_q >= LW'(RTS_THRESH));
        end
    end

    assign m.m_data   = m_data_q;
    assign m.m_valid  = m_valid_q;
    assign fifo_level = count_q;
    assign uart_rtsn  = rts_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_flow.sv
// Directed bench for uart_rx_flow at a reduced bit period (DIV=32).
module tb_uart_rx_flow;

    localparam int unsigned CLK_HZ = 3200;
    localparam int unsigned BAUD   = 100;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 12;
    localparam int unsigned LW     = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NB     = 10;
`else
    localparam int unsigned NB     = 9;
`endif
    // Negedges from start-bit drive to the cycle in which the push is presented
    localparam int unsigned PROBE  = NB * DIV + DIV / 2 + 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          uart_rtsn;
    logic [LW-1:0] fifo_level;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
    logic          par_flip = 1'b0;
    int unsigned   perr_cnt = 0;
`endif

    uart_rx_flow_if bus ();

    uart_rx_flow #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH),
        .RTS_THRESH(THRESH)
    ) dut (
        .clk_100mhz(clk),
        .resetn    (resetn),
        .uart_rxd  (uart_rxd),
        .uart_rtsn (uart_rtsn),
        .m         (bus.master),
        .fifo_level(fifo_level),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ferr_cnt = 0;
    int unsigned ovr_cnt  = 0;
    int unsigned vcyc     = 0;
    logic [7:0]  rx_q [$];
    logic [LW-1:0] lvl_prev = '0;
    logic          rstn_prev = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        pflip;
        int unsigned exp_n;
        int unsigned exp_ferr;
        int unsigned exp_perr;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: collect popped bytes and pulse counts; check RTS tracks level.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.m_valid) vcyc++;
            if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_cnt++;
`endif
        end
        if (resetn && rstn_prev) begin
            total++;
            if (uart_rtsn !== (lvl_prev >= LW'(THRESH))) begin
                bad++;
                $display("FAIL rts_track: got %0b want %0b (prev level %0d)",
                         uart_rtsn, (lvl_prev >= LW'(THRESH)), lvl_prev);
            end
        end
        lvl_prev  = fifo_level;
        rstn_prev = resetn;
    end

    // Drive one frame starting at the current negedge; a 0 stop bit holds the
    // line low for extra cycles to form a break.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned hold);
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = (^d) ^ par_flip;
        repeat (DIV) @(negedge clk);
`endif
        uart_rxd = stop;
        repeat (DIV) @(negedge clk);
        if (!stop) repeat (hold) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic pop_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.m_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic clear_counts();
        rx_q.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        vcyc     = 0;
`ifdef UART_RX_PARITY_EN
        perr_cnt = 0;
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{8'h55, 1'b1, 1'b0, 1, 0, 0});
        vecs.push_back('{8'hA3, 1'b1, 1'b0, 1, 0, 0});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1, 0, 0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 1});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1, 0, 0});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 0, 1, 0});
`endif

        // Reset state
        bus.m_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(bus.m_valid), 0);
        check("rst_data",  32'(bus.m_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_rtsn",  32'(uart_rtsn), 1);
        check("rst_ferr",  32'(frame_err), 0);
        check("rst_ovr",   32'(overrun), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("rts_after_release", 32'(uart_rtsn), 0);
        repeat (4) @(negedge clk);

        // Table of single frames with m_ready held high
        bus.m_ready = 1'b1;
        foreach (vecs[k]) begin
            clear_counts();
`ifdef UART_RX_PARITY_EN
            par_flip = vecs[k].pflip;
            send_frame(vecs[k].data, vecs[k].stop, 80);
            par_flip = 1'b0;
            check("vec_perr", perr_cnt, vecs[k].exp_perr);
`else
            send_frame(vecs[k].data, vecs[k].stop, 80);
`endif
            repeat (2 * DIV) @(negedge clk);
            check("vec_nbytes", 32'(rx_q.size()), vecs[k].exp_n);
            if (rx_q.size() != 0) check("vec_byte", 32'(rx_q[0]), 32'(vecs[k].data));
            check("vec_vcyc",  vcyc, vecs[k].exp_n);
            check("vec_ferr",  ferr_cnt, vecs[k].exp_ferr);
            check("vec_ovr",   ovr_cnt, 0);
            check("vec_level", 32'(fifo_level), 0);
        end

        // Short low glitch on the idle line
        clear_counts();
        uart_rxd = 1'b0;
        repeat (DIV / 2 - 6) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_nbytes", 32'(rx_q.size()), 0);
        check("glitch_ferr",   ferr_cnt, 0);
        check("glitch_level",  32'(fifo_level), 0);
        send_frame(8'h5A, 1'b1, 0);
        repeat (2 * DIV) @(negedge clk);
        check("post_glitch_n", 32'(rx_q.size()), 1);
        if (rx_q.size() != 0) check("post_glitch_byte", 32'(rx_q[0]), 32'h5A);

        // Fill to full, then one more frame overruns
        bus.m_ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0);
        repeat (2 * DIV) @(negedge clk);
        check("fill_level", 32'(fifo_level), 16);
        check("fill_ovr",   ovr_cnt, 0);
        check("fill_rtsn",  32'(uart_rtsn), 1);
        check("fill_head",  32'(bus.m_data), 0);
        send_frame(8'h10, 1'b1, 0);
        repeat (2 * DIV) @(negedge clk);
        check("ovr_count", ovr_cnt, 1);
        check("ovr_level", 32'(fifo_level), 16);
        check("ovr_head",  32'(bus.m_data), 0);
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            pop_n(1);
            if (fifo_level == LW'(11)) check("rts_release", 32'(uart_rtsn), 0);
        end
        check("drain_n", 32'(rx_q.size()), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) check("drain_byte", 32'(rx_q[i]), i);
        end
        check("drain_valid", 32'(bus.m_valid), 0);

        // Push and pop on the same cycle while full
        clear_counts();
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 0);
        repeat (2 * DIV) @(negedge clk);
        check("full2_level", 32'(fifo_level), 16);
        fork
            send_frame(8'h99, 1'b1, 0);
            begin
                repeat (PROBE) @(negedge clk);
                bus.m_ready = 1'b1;
                @(negedge clk);
                bus.m_ready = 1'b0;
            end
        join
        repeat (2 * DIV) @(negedge clk);
        check("pp_ovr",   ovr_cnt, 0);
        check("pp_level", 32'(fifo_level), 16);
        check("pp_npop",  32'(rx_q.size()), 1);
        if (rx_q.size() != 0) check("pp_popped", 32'(rx_q[0]), 32'h20);
        check("pp_head",  32'(bus.m_data), 32'h21);
        clear_counts();
        pop_n(16);
        check("pp_drain_n", 32'(rx_q.size()), 16);
        if (rx_q.size() == 16) begin
            check("pp_drain_15", 32'(rx_q[14]), 32'h2F);
            check("pp_drain_last", 32'(rx_q[15]), 32'h99);
        end

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b1, 0);
        repeat (DIV) @(negedge clk);
        fork
            send_frame(8'hF0, 1'b1, 0);
            begin
                repeat (3 * DIV) @(negedge clk);
                resetn = 1'b0;
                repeat (4) @(negedge clk);
                check("midrst_valid", 32'(bus.m_valid), 0);
                check("midrst_data",  32'(bus.m_data), 0);
                check("midrst_level", 32'(fifo_level), 0);
                check("midrst_rtsn",  32'(uart_rtsn), 1);
                check("midrst_ferr",  32'(frame_err), 0);
                check("midrst_ovr",   32'(overrun), 0);
            end
        join
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_rts_release", 32'(uart_rtsn), 0);
        clear_counts();
        bus.m_ready = 1'b1;
        send_frame(8'h42, 1'b1, 0);
        repeat (2 * DIV) @(negedge clk);
        check("midrst_nbytes", 32'(rx_q.size()), 1);
        if (rx_q.size() != 0) check("midrst_byte", 32'(rx_q[0]), 32'h42);
        check("midrst_ferr_cnt", ferr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
